// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//
// Hazard and stall scheduler for the five-stage RISC-V pipeline.
//   * Operand-forwarding selects for the execute-stage ALU inputs.
//   * Stall / flush controls for the F, D, E, M and W pipeline registers.
//   * Freeze sequencing for multi-cycle data-memory accesses, with a timeout
//     FSM that aborts a hung access and squashes it before writeback.
//
// Ports
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   Rs1D, Rs2D               source registers of the instruction in decode
//   Rs1E, Rs2E               source registers of the instruction in execute
//   RdE, RdM, RdW            destination registers in E / M / W
//   RegWriteM, RegWriteW     destination write enables in M / W
//   LoadE                    instruction in E is a load
//   PCSrcE                   taken branch or jump resolved in E
//   MemReqM, MemReadyM       data-memory request in M / access completes now
//   ForwardAE, ForwardBE     ALU operand select: 00 RF, 10 M result, 01 W result
//   StallF..StallM           hold the register feeding the named stage
//   FlushD, FlushE, FlushW   load a bubble into D / E / W at the next edge
//   MemErr                   one-cycle pulse when a memory access is aborted
//   State                    FSM state: RUN=00, WAIT=01, ABORT=10
// ---------------------------------------------------------------------------
module hazard_controller #(
   parameter int unsigned MEM_TIMEOUT = 15,  // 0 disables the timeout
   parameter int unsigned CNT_W       = 4    // must hold MEM_TIMEOUT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       LoadE,
   input  logic       PCSrcE,
   input  logic       MemReqM,
   input  logic       MemReadyM,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushW,
   output logic       MemErr,
   output logic [1:0] State
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_WAIT  = 2'b01,
      ST_ABORT = 2'b10
   } state_t;

   localparam logic             TIMEOUT_EN = (MEM_TIMEOUT != 0);
   localparam logic [CNT_W:0]   TIMEOUT_V  = (CNT_W+1)'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic memstall;
   logic loaduse;
   logic last_stall;

   // M-stage result is younger than W-stage result, so it wins.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       we_m,
      input logic [4:0] rd_w,
      input logic       we_w
   );
      if (we_m && (rd_m != 5'd0) && (rd_m == rs))
         return 2'b10;
      else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign memstall = (state_q != ST_ABORT) && MemReqM && !MemReadyM;
   assign loaduse  = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

   // cnt_q counts stalled cycles already completed for this access (0 in RUN),
   // so the current stalled cycle is number cnt_q+1. Aborting when that equals
   // MEM_TIMEOUT gives exactly MEM_TIMEOUT stalled cycles before ABORT, and
   // covers MEM_TIMEOUT==1 (RUN straight to ABORT) with the same comparison.
   assign last_stall = TIMEOUT_EN && (({1'b0, cnt_q} + (CNT_W+1)'(1)) == TIMEOUT_V);

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case/if tree leaves a variable unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (memstall) begin
               if (last_stall) begin
                  state_d = ST_ABORT;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         ST_WAIT: begin
            if (!memstall) begin
               // MemReadyM arrived or the request went away.
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (last_stall) begin
               state_d = ST_ABORT;
               cnt_d   = '0;
            end else begin
               // Saturate so a disabled timeout never wraps the counter.
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
         end
         ST_ABORT: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode. Priority: ABORT > memstall > taken branch > load-use.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      MemErr    = 1'b0;
      State     = 2'b00;
      if (!reset) begin
         State     = state_q;
         ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
         ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
         if (state_q == ST_ABORT) begin
            // Let the pipeline move and turn the hung M instruction into a
            // bubble at W.
            FlushW = 1'b1;
            MemErr = 1'b1;
         end else if (memstall) begin
            // Whole front end frozen; W gets bubbles. A branch sitting in E
            // is held and takes effect in the release cycle.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (PCSrcE) begin
            // The redirect discards the dependent instruction anyway.
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (loaduse) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//
// Directed bench for hazard_controller built with MEM_TIMEOUT=4. Inputs are
// driven 1 time unit after the rising edge and outputs are checked 1 time
// unit later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

   localparam int unsigned TO = 4;

   // Packed view of the control outputs:
   // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
   localparam logic [7:0] CTL_NONE = 8'b0000_0000;
   localparam logic [7:0] CTL_LU   = 8'b1100_0100;
   localparam logic [7:0] CTL_BR   = 8'b0000_1100;
   localparam logic [7:0] CTL_MEM  = 8'b1111_0010;
   localparam logic [7:0] CTL_ABT  = 8'b0000_0011;

   logic       clock;
   logic       reset;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushW, MemErr;
   logic [1:0] State;
   logic [7:0] ctl;

   int total;
   int bad;

   assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr};

   hazard_controller #(
      .MEM_TIMEOUT(TO),
      .CNT_W      (4)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .Rs1D     (Rs1D),
      .Rs2D     (Rs2D),
      .Rs1E     (Rs1E),
      .Rs2E     (Rs2E),
      .RdE      (RdE),
      .RdM      (RdM),
      .RdW      (RdW),
      .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW),
      .LoadE    (LoadE),
      .PCSrcE   (PCSrcE),
      .MemReqM  (MemReqM),
      .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE),
      .ForwardBE(ForwardBE),
      .StallF   (StallF),
      .StallD   (StallD),
      .StallE   (StallE),
      .StallM   (StallM),
      .FlushD   (FlushD),
      .FlushE   (FlushE),
      .FlushW   (FlushW),
      .MemErr   (MemErr),
      .State    (State)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic clear_inputs();
      Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
      RdE  = 5'd0; RdM  = 5'd0; RdW  = 5'd0;
      RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0;
      MemReqM = 1'b0; MemReadyM = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      // Inputs that would produce forwarding, load-use and a memory stall.
      Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
      LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; MemReqM = 1'b1;
      #2;
      total++;
      if ({ForwardAE, ForwardBE, ctl, State} !== 12'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=0", {ForwardAE, ForwardBE, ctl, State});
      end
      clear_inputs();
      @(negedge clock);
      reset = 1'b0;
      next_cycle();
      #1;
      total++;
      if (State !== 2'b00 || ctl !== CTL_NONE) begin
         bad++;
         $display("FAIL reset_release state=%b ctl=%b want state=00 ctl=%b", State, ctl, CTL_NONE);
      end
   endtask

   task automatic test_forwarding();
      next_cycle();
      clear_inputs();
      Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
      Rs2E = 5'd3;
      #1;
      total++;
      if (ForwardAE !== 2'b10 || ForwardBE !== 2'b00) begin
         bad++;
         $display("FAIL fwd_m_priority A=%b B=%b want A=10 B=00", ForwardAE, ForwardBE);
      end
      RegWriteM = 1'b0;
      #1;
      total++;
      if (ForwardAE !== 2'b01) begin
         bad++;
         $display("FAIL fwd_w A=%b want=01", ForwardAE);
      end
      Rs1E = 5'd0; RdM = 5'd0; RegWriteM = 1'b1; RdW = 5'd0; RegWriteW = 1'b1;
      #1;
      total++;
      if (ForwardAE !== 2'b00) begin
         bad++;
         $display("FAIL fwd_x0 A=%b want=00", ForwardAE);
      end
      Rs2E = 5'd9; RdM = 5'd9; RdW = 5'd9;
      #1;
      total++;
      if (ForwardBE !== 2'b10 || ForwardAE !== 2'b00) begin
         bad++;
         $display("FAIL fwd_b_m A=%b B=%b want A=00 B=10", ForwardAE, ForwardBE);
      end
      RdM = 5'd4;
      #1;
      total++;
      if (ForwardBE !== 2'b01) begin
         bad++;
         $display("FAIL fwd_b_w B=%b want=01", ForwardBE);
      end
      clear_inputs();
   endtask

   task automatic test_load_use();
      next_cycle();
      LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
      #1;
      total++;
      if (ctl !== CTL_LU || State !== 2'b00) begin
         bad++;
         $display("FAIL loaduse_on ctl=%b state=%b want ctl=%b state=00", ctl, State, CTL_LU);
      end
      next_cycle();
      LoadE = 1'b0;
      #1;
      total++;
      if (ctl !== CTL_NONE) begin
         bad++;
         $display("FAIL loaduse_off ctl=%b want=%b", ctl, CTL_NONE);
      end
      // Load to x0 never creates a dependency.
      LoadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
      #1;
      total++;
      if (ctl !== CTL_NONE) begin
         bad++;
         $display("FAIL loaduse_x0 ctl=%b want=%b", ctl, CTL_NONE);
      end
      clear_inputs();
   endtask

   task automatic test_branch_vs_load_use();
      next_cycle();
      LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
      #1;
      total++;
      if (ctl !== CTL_BR) begin
         bad++;
         $display("FAIL branch_over_loaduse ctl=%b want=%b", ctl, CTL_BR);
      end
      clear_inputs();
   endtask

   // Ready after 3 low cycles; a taken branch waits in E for the release.
   task automatic test_mem_wait();
      logic [7:0] exp_ctl [4] = '{CTL_MEM, CTL_MEM, CTL_MEM, CTL_BR};
      logic [1:0] exp_st  [4] = '{2'b00, 2'b01, 2'b01, 2'b01};
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         MemReqM   = 1'b1;
         MemReadyM = (i == 3);
         PCSrcE    = 1'b1;
         #1;
         total++;
         if (ctl !== exp_ctl[i] || State !== exp_st[i]) begin
            bad++;
            $display("FAIL mem_wait_c%0d ctl=%b state=%b want ctl=%b state=%b",
                     i + 1, ctl, State, exp_ctl[i], exp_st[i]);
         end
      end
      next_cycle();
      clear_inputs();
      #1;
      total++;
      if (ctl !== CTL_NONE || State !== 2'b00) begin
         bad++;
         $display("FAIL mem_wait_after ctl=%b state=%b want ctl=0 state=00", ctl, State);
      end
   endtask

   // Two consecutive timeouts; the second ABORT cycle sees MemReqM dropped
   // and MemReadyM raised, which it must ignore.
   task automatic test_timeout();
      logic [7:0] exp_ctl;
      logic [1:0] exp_st;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         MemReqM   = (i != 9);
         MemReadyM = (i == 9);
         case (i % 5)
            0:       begin exp_ctl = CTL_MEM; exp_st = 2'b00; end
            4:       begin exp_ctl = CTL_ABT; exp_st = 2'b10; end
            default: begin exp_ctl = CTL_MEM; exp_st = 2'b01; end
         endcase
         #1;
         total++;
         if (ctl !== exp_ctl || State !== exp_st) begin
            bad++;
            $display("FAIL timeout_c%0d ctl=%b state=%b want ctl=%b state=%b",
                     i + 1, ctl, State, exp_ctl, exp_st);
         end
      end
      next_cycle();
      clear_inputs();
      #1;
      total++;
      if (ctl !== CTL_NONE || State !== 2'b00) begin
         bad++;
         $display("FAIL timeout_after ctl=%b state=%b want ctl=0 state=00", ctl, State);
      end
   endtask

   // Release followed immediately by a new request: the new one must get a
   // full TO stalled cycles.
   task automatic test_back_to_back();
      logic       req [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       rdy [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [7:0] exp_ctl [9] = '{CTL_MEM, CTL_MEM, CTL_NONE, CTL_MEM, CTL_MEM,
                                  CTL_MEM, CTL_MEM, CTL_ABT, CTL_NONE};
      logic [1:0] exp_st  [9] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01,
                                  2'b01, 2'b01, 2'b10, 2'b00};
      for (int i = 0; i < 9; i++) begin
         next_cycle();
         MemReqM   = req[i];
         MemReadyM = rdy[i];
         #1;
         total++;
         if (ctl !== exp_ctl[i] || State !== exp_st[i]) begin
            bad++;
            $display("FAIL b2b_c%0d ctl=%b state=%b want ctl=%b state=%b",
                     i + 1, ctl, State, exp_ctl[i], exp_st[i]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_async_reset_wait();
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         MemReqM = 1'b1;
      end
      Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
      #1;
      total++;
      if (State !== 2'b01 || ctl !== CTL_MEM || ForwardAE !== 2'b10) begin
         bad++;
         $display("FAIL areset_pre state=%b ctl=%b A=%b want state=01 ctl=%b A=10",
                  State, ctl, ForwardAE, CTL_MEM);
      end
      // Mid-cycle, well before the next edge.
      #1;
      reset = 1'b1;
      #1;
      total++;
      if ({ForwardAE, ForwardBE, ctl, State} !== 12'd0) begin
         bad++;
         $display("FAIL areset_outputs got=%b want=0", {ForwardAE, ForwardBE, ctl, State});
      end
      clear_inputs();
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         logic [7:0] exp_ctl;
         logic [1:0] exp_st;
         next_cycle();
         MemReqM = (i < 5);
         case (i)
            0:       begin exp_ctl = CTL_MEM;  exp_st = 2'b00; end
            4:       begin exp_ctl = CTL_ABT;  exp_st = 2'b10; end
            5:       begin exp_ctl = CTL_NONE; exp_st = 2'b00; end
            default: begin exp_ctl = CTL_MEM;  exp_st = 2'b01; end
         endcase
         #1;
         total++;
         if (ctl !== exp_ctl || State !== exp_st) begin
            bad++;
            $display("FAIL areset_new_c%0d ctl=%b state=%b want ctl=%b state=%b",
                     i + 1, ctl, State, exp_ctl, exp_st);
         end
      end
      clear_inputs();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_vs_load_use();
      test_mem_wait();
      test_timeout();
      test_back_to_back();
      test_async_reset_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog bench did not finish by time=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
